// File: rtl/thread_scheduler_pkg.sv
// io881_sched_pkg: shared constants and FSM encoding for the io881 thread scheduler
package io881_sched_pkg;
    localparam int DEF_NTHREADS = 32;
    localparam int DEF_TIDW = 5;
    localparam int DEF_PCW = 12;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_RUN = 3'd3;
    localparam logic [2:0] S_WB = 3'd4;
    localparam logic [DEF_NTHREADS-1:0] RESET_MASK = DEF_NTHREADS'(1);
endpackage

// File: rtl/thread_scheduler_if.sv
// thread_scheduler_if: core-side control and PC-store bus of the thread scheduler
interface thread_scheduler_if
    import io881_sched_pkg::*;
#(
    parameter int TIDW = DEF_TIDW,
    parameter int PCW = DEF_PCW
);
    logic wake;
    logic [TIDW-1:0] wake_id;
    logic run_done;
    logic [PCW-1:0] next_pc;
    logic block;
    logic run;
    logic [TIDW-1:0] cur_tid;
    logic idle;
    logic [TIDW-1:0] rthreadid;
    logic [TIDW-1:0] wthreadid;
    logic [PCW-1:0] dpc;
    logic wepc;
    modport master (
        output wake, wake_id, run_done, next_pc, block,
        input run, cur_tid, idle, rthreadid, wthreadid, dpc, wepc
    );
    modport slave (
        input wake, wake_id, run_done, next_pc, block,
        output run, cur_tid, idle, rthreadid, wthreadid, dpc, wepc
    );
endinterface

// File: rtl/thread_scheduler_rr_pick.sv
// rr_pick: combinational round-robin priority encoder searching upward from last+1
module rr_pick #(
    parameter int N = 32,
    parameter int W = 5
) (
    input logic [N-1:0] mask_i,
    input logic [W-1:0] last_i,
    output logic [W-1:0] id_o,
    output logic found_o
);
    // scan farthest-first so the nearest ready thread after last wins
    always_comb begin
        id_o = last_i;
        for (int i = N; i >= 1; i--)
            if (mask_i[last_i + W'(i)]) id_o = last_i + W'(i);
        found_o = |mask_i;
    end
endmodule

// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin scheduler driving the PC store of the io881 hardware threads
// Optional THREAD_SCHED_IRQ_PRIORITY_EN: thread 0 wins selection whenever it is ready.
module thread_scheduler
    import io881_sched_pkg::*;
#(
    parameter int NTHREADS = DEF_NTHREADS,
    parameter int TIDW = DEF_TIDW,
    parameter int PCW = DEF_PCW
) (
    input logic clk,
    input logic reset,
    thread_scheduler_if.slave bus
);
    logic [2:0] state_q, state_d;
    logic [NTHREADS-1:0] mask_q, mask_d, set_m, clr_m;
    logic [TIDW-1:0] last_q, last_d, cur_tid_q, cur_tid_d, wthreadid_q, wthreadid_d;
    logic [TIDW-1:0] rr_id, pick_id;
    logic [PCW-1:0] dpc_q, dpc_d;
    logic run_q, run_d, idle_q, idle_d, wepc_q, wepc_d, found, slice_end;

    rr_pick #(.N(NTHREADS), .W(TIDW)) u_pick (
        .mask_i(mask_q),
        .last_i(last_q),
        .id_o(rr_id),
        .found_o(found)
    );

`ifdef THREAD_SCHED_IRQ_PRIORITY_EN
    assign pick_id = mask_q[0] ? '0 : rr_id;
`else
    assign pick_id = rr_id;
`endif

    assign slice_end = (state_q == S_RUN) && bus.run_done;

    // ready-mask update (block-clear then wake-set), FSM next state and registered outputs
    always_comb begin
        set_m = bus.wake ? NTHREADS'(1) << bus.wake_id : '0;
        clr_m = (slice_end && bus.block) ? NTHREADS'(1) << cur_tid_q : '0;
        mask_d = (mask_q & ~clr_m) | set_m;
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = (|mask_d) ? S_SELECT : S_IDLE;
            S_SELECT: state_d = found ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_RUN;
            S_RUN: state_d = bus.run_done ? S_WB : S_RUN;
            S_WB: state_d = (|mask_d) ? S_SELECT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cur_tid_d = (state_q == S_SELECT && found) ? pick_id : cur_tid_q;
        last_d = (state_q == S_SELECT && found) ? pick_id : last_q;
        wepc_d = slice_end;
        wthreadid_d = slice_end ? cur_tid_q : wthreadid_q;
        dpc_d = slice_end ? bus.next_pc : dpc_q;
        run_d = state_d == S_RUN;
        idle_d = state_d == S_IDLE;
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_SELECT;
            mask_q <= NTHREADS'(RESET_MASK);
            last_q <= TIDW'(NTHREADS - 1);
            cur_tid_q <= '0;
            wthreadid_q <= '0;
            dpc_q <= '0;
            wepc_q <= 1'b0;
            run_q <= 1'b0;
            idle_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q <= mask_d;
            last_q <= last_d;
            cur_tid_q <= cur_tid_d;
            wthreadid_q <= wthreadid_d;
            dpc_q <= dpc_d;
            wepc_q <= wepc_d;
            run_q <= run_d;
            idle_q <= idle_d;
        end
    end

    assign bus.run = run_q;
    assign bus.cur_tid = cur_tid_q;
    assign bus.rthreadid = cur_tid_q;
    assign bus.idle = idle_q;
    assign bus.wthreadid = wthreadid_q;
    assign bus.dpc = dpc_q;
    assign bus.wepc = wepc_q;
endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: scoreboard bench for thread_scheduler selections and PC write-backs
module tb_thread_scheduler;
    import io881_sched_pkg::*;

    typedef struct {
        logic [4:0] tid;
        logic [11:0] pc;
    } wb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    wb_t wb_q[$];
    logic [4:0] sel_q[$];
    wb_t we;
    logic [4:0] se;
    logic run_prev = 1'b0;
    int n;

    thread_scheduler_if #(.TIDW(5), .PCW(12)) bus ();

    thread_scheduler dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor: pop expectations on each new slice start and each PC write pulse
    always @(negedge clk) begin
        if (bus.run && !run_prev) begin
            if (sel_q.size() == 0) chk("sel_unexpected", 32'(bus.cur_tid), 32'hFFFF);
            else begin
                se = sel_q.pop_front();
                chk("sel_cur_tid", 32'(bus.cur_tid), 32'(se));
                chk("sel_rthreadid", 32'(bus.rthreadid), 32'(se));
            end
        end
        if (bus.wepc) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 32'(bus.wthreadid), 32'hFFFF);
            else begin
                we = wb_q.pop_front();
                chk("wb_wthreadid", 32'(bus.wthreadid), 32'(we.tid));
                chk("wb_dpc", 32'(bus.dpc), 32'(we.pc));
            end
        end
        run_prev = bus.run;
    end

    task automatic wait_run(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.run && cnt < 40);
        if (!bus.run) chk("run_timeout", 32'(bus.run), 1);
    endtask

    task automatic pulse_wake(input logic [4:0] id);
        @(posedge clk);
        #1 bus.wake = 1'b1;
        bus.wake_id = id;
        @(posedge clk);
        #1 bus.wake = 1'b0;
    endtask

    task automatic end_slice(input logic blk, input logic [11:0] pc, input logic wk, input logic [4:0] wid);
        @(posedge clk);
        #1 bus.run_done = 1'b1;
        bus.block = blk;
        bus.next_pc = pc;
        bus.wake = wk;
        bus.wake_id = wid;
        @(posedge clk);
        #1 bus.run_done = 1'b0;
        bus.block = 1'b0;
        bus.wake = 1'b0;
    endtask

    task automatic expect_slice(input logic [4:0] tid, input logic [11:0] pc, input logic [4:0] nxt);
        wb_q.push_back('{tid: tid, pc: pc});
        sel_q.push_back(nxt);
    endtask

    initial begin
        bus.wake = 1'b0;
        bus.wake_id = '0;
        bus.run_done = 1'b0;
        bus.next_pc = '0;
        bus.block = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_run", 32'(bus.run), 0);
        chk("reset_idle", 32'(bus.idle), 0);
        chk("reset_wepc", 32'(bus.wepc), 0);
        chk("reset_cur_tid", 32'(bus.cur_tid), 0);
        chk("reset_wthreadid", 32'(bus.wthreadid), 0);
        chk("reset_dpc", 32'(bus.dpc), 0);
        sel_q.push_back(5'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_run(n);
        chk("reset_to_run_cycles", 32'(n), 3);
        chk("run_idle", 32'(bus.idle), 0);

        expect_slice(5'd0, 12'hAAA, 5'd0);
        end_slice(1'b0, 12'hAAA, 1'b0, 5'd0);
        wait_run(n);
        chk("slice_gap", 32'(n - 1), 3);

        pulse_wake(5'd4);
`ifdef THREAD_SCHED_IRQ_PRIORITY_EN
        expect_slice(5'd0, 12'h123, 5'd0);
`else
        expect_slice(5'd0, 12'h123, 5'd4);
`endif
        end_slice(1'b0, 12'h123, 1'b0, 5'd0);
        wait_run(n);

        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 sel_q.push_back(5'd0);
        reset = 1'b0;
        wait_run(n);

        pulse_wake(5'd3);
        pulse_wake(5'd7);
        expect_slice(5'd0, 12'h111, 5'd3);
        end_slice(1'b1, 12'h111, 1'b0, 5'd0);
        wait_run(n);
        expect_slice(5'd3, 12'h333, 5'd7);
        end_slice(1'b1, 12'h333, 1'b0, 5'd0);
        wait_run(n);
        wb_q.push_back('{tid: 5'd7, pc: 12'h777});
        end_slice(1'b1, 12'h777, 1'b0, 5'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.idle && n < 40);
        chk("idle_reached", 32'(bus.idle), 1);
        chk("idle_run", 32'(bus.run), 0);
        chk("idle_cycles", 32'(n), 2);

        sel_q.push_back(5'd31);
        pulse_wake(5'd31);
        wait_run(n);
        chk("wake_to_run_cycles", 32'(n), 3);
        pulse_wake(5'd2);
        expect_slice(5'd31, 12'h031, 5'd2);
        end_slice(1'b0, 12'h031, 1'b0, 5'd0);
        wait_run(n);
        expect_slice(5'd2, 12'h002, 5'd31);
        end_slice(1'b0, 12'h002, 1'b0, 5'd0);
        wait_run(n);
        expect_slice(5'd31, 12'h131, 5'd2);
        end_slice(1'b1, 12'h131, 1'b0, 5'd0);
        wait_run(n);
        pulse_wake(5'd5);
        expect_slice(5'd2, 12'h202, 5'd5);
        end_slice(1'b1, 12'h202, 1'b0, 5'd0);
        wait_run(n);

        expect_slice(5'd5, 12'h505, 5'd5);
        end_slice(1'b1, 12'h505, 1'b1, 5'd5);
        wait_run(n);

        wb_q.push_back('{tid: 5'd5, pc: 12'h5AB});
        @(posedge clk);
        #1 bus.run_done = 1'b1;
        bus.next_pc = 12'h5AB;
        @(posedge clk);
        #1 bus.run_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wb_reset_wepc", 32'(bus.wepc), 0);
        chk("wb_reset_cur_tid", 32'(bus.cur_tid), 0);
        chk("wb_reset_run", 32'(bus.run), 0);
        sel_q.push_back(5'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_run(n);
        chk("post_abort_run_cycles", 32'(n), 3);
        repeat (4) @(negedge clk);
        chk("wb_queue_drained", 32'(wb_q.size()), 0);
        chk("sel_queue_drained", 32'(sel_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Round-robin thread scheduler that sequences the per-thread special register file (PC store) for the 32 hardware threads of the io881 core. It keeps a ready mask, selects the next ready thread and drives its `rthreadid` so the core fetches from that thread's PC. When the core finishes a slice, it writes the returned PC back through `wthreadid`/`dpc`/`wepc`. It sits between the core's issue control and the process special regs block.

## Interface
- `NTHREADS`, 32, number of hardware threads (power of two)
- `TIDW`, 5, thread-id width, equal to log2(NTHREADS)
- `PCW`, 12, PC width
- `clk` in 1: sole clock; all state updates on posedge
- `reset` in 1: synchronous, active-high
- `wake` in 1: set the ready bit of `wake_id` this cycle
- `wake_id` in TIDW: thread to wake
- `run_done` in 1: core has finished the current slice; sampled only in RUN
- `next_pc` in PCW: PC to store for the current thread, valid with `run_done`
- `block` in 1: with `run_done`, clear the current thread's ready bit
- `run` out 1: current thread is executing; `qpc` is valid for `cur_tid`
- `cur_tid` out TIDW: thread being executed
- `idle` out 1: no thread is ready
- `rthreadid` out TIDW: read select to the PC store
- `wthreadid` out TIDW: write select to the PC store
- `dpc` out PCW: write data to the PC store
- `wepc` out 1: PC write enable, one-cycle pulse

## Operation
- All outputs are registered.
- Reset values:
  - `run`, `idle`, `wepc` = 0
  - `cur_tid`, `rthreadid`, `wthreadid` = 0; `dpc` = 0
  - ready mask = 1 (only thread 0 ready); last-served pointer = NTHREADS-1
  - state = SELECT
- States:
  - IDLE: `idle`=1. Leaves for SELECT on the first cycle the ready mask is nonzero, counting a wake in that same cycle.
  - SELECT: pick the first ready thread searching upward from last+1, wrapping modulo NTHREADS. Register it into `cur_tid`/`rthreadid` and the last pointer, then go to FETCH. If the mask is empty (possible only via reset-free corner cases), go to IDLE.
  - FETCH: one settle cycle for `qpc`, then go to RUN.
  - RUN: `run`=1. On `run_done`: register `wthreadid`=`cur_tid` and `dpc`=`next_pc`, set `wepc`=1, apply `block`, then go to WB.
  - WB: `wepc` is high this cycle only. Next state is SELECT if the mask is nonzero, else IDLE. `run`=0.
- Ready-mask update: each cycle, apply block-clear first and then wake-set. If a thread is woken and blocked in the same cycle, it remains ready. Waking an already-ready thread has no effect.
- A thread that does not block stays eligible. When it is the only ready thread, it is reselected immediately.
- Reset mid-operation aborts any slice. `wepc` is low from the cycle after reset is sampled, and no write is issued.

## Timing
- `run_done` sampled at edge E:
  - `wepc`/`wthreadid`/`dpc` are valid after E, for one cycle.
  - E+1: SELECT.
  - E+2: FETCH; the new `rthreadid` is visible.
  - E+3: RUN; `run`=1.
- Slice-to-slice gap is 3 cycles with `run`=0.
- After reset deasserts at edge R, `run`=1 and `cur_tid`=0 after edge R+2.
- A wake while in IDLE at edge W gives `run`=1 after edge W+3.
- `run_done` outside RUN is ignored. `next_pc` is truncated to PCW bits.

## Configuration
- `THREAD_SCHED_IRQ_PRIORITY_EN` defined: in SELECT, thread 0 is chosen whenever it is ready, regardless of the round-robin pointer. The pointer is updated to 0.
- Undefined: pure round-robin; thread 0 has no special treatment.

## Structure
- Package `io881_sched_pkg` holds:
  - the state encoding (IDLE, SELECT, FETCH, RUN, WB)
  - default `NTHREADS`/`TIDW`/`PCW` constants
  - the reset ready mask
- Sub-module `rr_pick` is a combinational round-robin priority encoder. Inputs are the mask and the last pointer; outputs are the chosen id and a `found` flag. It is instantiated once.

## Test plan
- Reset, leave `run_done` low → after edge R+2, `run`=1, `cur_tid`=0, `rthreadid`=0, `idle`=0.
- Slice end, `run_done` with `next_pc`=12'hAAA and `block`=0 → one `wepc` pulse with `wthreadid`=0 and `dpc`=AAA. Thread 0 is reselected and `run`=1 three cycles later.
- Wake 3 and 7 while thread 0 runs, then end slices with `block`=1 each time → selection order is 3, 7, then IDLE (`idle`=1, `run`=0).
- Pointer wrap: ready threads {31, 2}, last=31 → 2 is chosen next, then 31.
- `wake_id`=5 and `block`=1 on current thread 5 in the same cycle → 5 stays ready and is reselected. Assert reset during WB → `wepc`=0 next cycle and `cur_tid`=0.
- With the macro defined, ready threads {0, 4}, last=0 → thread 0 is chosen again over 4. Without the macro → thread 4 is chosen.
